ram_bank: RTL and testbench
===========================

Name: ram_bank

Overview:
- Single-clock, parametrised block RAM with two ports.
  - Port A: read/write with byte enables.
  - Port B: read-only, e.g. video/DMA fetch.
- Adds three things the plain RAM wrappers lack: selectable read latency, byte-lane writes, and a hardware clear engine that fills the whole array with a constant after reset or on request.
- Sits between the core bus logic and on-chip memory, e.g. system RAM and colour/video RAM that must come up in a known state.

Parameters:
- DATAWIDTH, 16, word width in bits; must be a multiple of BYTEWIDTH.
- ADDRWIDTH, 10, address width; depth = 2**ADDRWIDTH words.
- BYTEWIDTH, 8, bits per byte lane; NB = DATAWIDTH/BYTEWIDTH lanes.
- OUTREG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.
- CLEAR_ON_RESET, 1, 1 = reset starts a full-array clear; 0 = reset leaves contents untouched.
- CLEAR_VALUE, 0, DATAWIDTH-bit word written to every location by the clear engine.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  one-cycle request to start a full-array clear.
- busy  out  1  high while the clear engine owns the array.
- address_a  in  ADDRWIDTH  port A address.
- data_a  in  DATAWIDTH  port A write data.
- wren_a  in  1  port A write enable.
- byteena_a  in  NB  port A byte-lane enables; bit i covers data bits [i*BYTEWIDTH +: BYTEWIDTH].
- q_a  out  DATAWIDTH  port A read data.
- address_b  in  ADDRWIDTH  port B address.
- q_b  out  DATAWIDTH  port B read data.

Behaviour:
- One clock; reset is synchronous and active-high. Contents are never reset, only overwritten by the clear engine.
- Reset values:
  - q_a = 0, q_b = 0, including the OUTREG stage.
  - busy = CLEAR_ON_RESET.
  - Clear counter = 0.
- FSM states: IDLE, CLEAR.
  - reset -> CLEAR if CLEAR_ON_RESET, else IDLE. Reset asserted mid-clear restarts the clear from address 0.
  - IDLE with clear=1 -> CLEAR at the next edge. busy rises that same edge.
  - CLEAR: writes CLEAR_VALUE (all lanes) to address = counter each cycle, then increments the counter. After writing the address 2**ADDRWIDTH-1: counter wraps to 0, state -> IDLE, busy falls at that edge.
  - Clear time: exactly 2**ADDRWIDTH cycles with busy high.
  - clear asserted while already in CLEAR: ignored, no restart.
- While busy:
  - wren_a is ignored; no user write reaches the array.
  - q_a and q_b capture CLEAR_VALUE instead of array data.
- Port A write, IDLE only: when wren_a=1, each lane with byteena_a[i]=1 takes data_a's lane; lanes with 0 keep their stored value. byteena_a = 0 is a no-op.
- Read latency, both ports: address presented at edge N.
  - OUTREG=0: data on q at edge N+1.
  - OUTREG=1: data on q at edge N+2.
  - Reads are fully pipelined, one per cycle.
- Port A read-during-write, same address: q_a returns the new merged word (new data in enabled lanes, old data in the others).
- Port B reading the address port A writes in the same cycle: q_b returns the old word; the new word is visible from the next read.
- No handshakes or stalls other than busy; callers must hold off writes until busy=0.

Test Plan:
Configuration for all scenarios: DATAWIDTH=16, ADDRWIDTH=4, BYTEWIDTH=8.
1. Reset with CLEAR_ON_RESET=1, CLEAR_VALUE=16'hA5A5 -> busy high for exactly 16 cycles, then 0. Reading all 16 addresses on port B afterwards returns 16'hA5A5.
2. OUTREG=0, IDLE: write 16'h1234 with byteena_a=2'b11 to addr 3, then read addr 3 -> q_a=16'h1234 one cycle after the read address; q_b=16'h1234 at the same latency.
3. Byte lanes: addr 5 holds 16'h1234; write 16'hABCD with byteena_a=2'b01 -> 16'h12CD. Then write 16'hEF00 with 2'b10 -> 16'hEFCD. A write with 2'b00 leaves 16'hEFCD.
4. Same-cycle collision at addr 7 (old 16'h0000, write 16'h5555 on A, read on B) -> q_a=16'h5555, q_b=16'h0000; the next port B read returns 16'h5555.
5. OUTREG=1 -> reads issued on 3 consecutive cycles to addresses 1, 2, 3 appear on q_a on 3 consecutive cycles, each 2 cycles after its address.
6. Pulse clear in IDLE, wait 5 cycles, pulse clear again, assert wren_a during the clear -> clear not restarted; busy high for 16 total cycles; the user write has no effect. Then pulse reset mid-clear -> counter restarts at 0, busy stays high for 16 more cycles.

Source files
------------

// File: rtl/ram_bank_if.sv
// Port bundle for ram_bank: read/write port A, read-only port B, and the clear request/busy pair.
// The clock and reset stay outside the bundle. The memory side uses slave; the requester side uses master.
interface ram_bank_if #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 10,
    parameter int BYTEWIDTH = 8
);
    localparam int NB = DATAWIDTH / BYTEWIDTH;

    logic                 clear;
    logic                 busy;
    logic [ADDRWIDTH-1:0] address_a;
    logic [DATAWIDTH-1:0] data_a;
    logic                 wren_a;
    logic [NB-1:0]        byteena_a;
    logic [DATAWIDTH-1:0] q_a;
    logic [ADDRWIDTH-1:0] address_b;
    logic [DATAWIDTH-1:0] q_b;

    modport master (
        output clear, address_a, data_a, wren_a, byteena_a, address_b,
        input  busy, q_a, q_b
    );

    modport slave (
        input  clear, address_a, data_a, wren_a, byteena_a, address_b,
        output busy, q_a, q_b
    );
endinterface

// File: rtl/ram_bank.sv
// Two-port block RAM: port A is read/write with byte lanes, port B is read-only, and a clear engine fills the array.
// Read latency is 1 cycle, or 2 cycles when OUTREG=1. Reads are fully pipelined.
// There is no backpressure. While busy is high, port A writes are dropped and both read ports return CLEAR_VALUE.
module ram_bank #(
    parameter int                   DATAWIDTH      = 16,
    parameter int                   ADDRWIDTH      = 10,
    parameter int                   BYTEWIDTH      = 8,
    parameter int                   OUTREG         = 0,
    parameter int                   CLEAR_ON_RESET = 1,
    parameter logic [DATAWIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic        clock,
    input  logic        reset,
    ram_bank_if.slave   bus
);
    localparam int NB    = DATAWIDTH / BYTEWIDTH;
    localparam int DEPTH = 1 << ADDRWIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state, state_nxt;
    logic [ADDRWIDTH-1:0] clr_cnt, clr_cnt_nxt;
    logic                 busy_int;
    logic [NB-1:0]        lane_we;
    logic [ADDRWIDTH-1:0] mem_waddr;
    logic [DATAWIDTH-1:0] mem_wdat;
    logic [DATAWIDTH-1:0] rd_a;
    logic [DATAWIDTH-1:0] merged_a;
    logic [DATAWIDTH-1:0] q_a_s1, q_b_s1;

    logic [DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy_int    = 1'b0;
        lane_we     = '0;
        mem_waddr   = bus.address_a;
        mem_wdat    = bus.data_a;
        case (state)
            IDLE: begin
                if (bus.wren_a) lane_we = bus.byteena_a;
                if (bus.clear)  state_nxt = CLEAR;
            end
            CLEAR: begin
                busy_int    = 1'b1;
                lane_we     = '1;
                mem_waddr   = clr_cnt;
                mem_wdat    = CLEAR_VALUE;
                clr_cnt_nxt = clr_cnt + ADDRWIDTH'(1);
                if (clr_cnt == {ADDRWIDTH{1'b1}}) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Block writes in the reset cycle so a reset during a clear cannot leave a stray write behind.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NB; i++) begin
                if (lane_we[i]) mem[mem_waddr][i*BYTEWIDTH +: BYTEWIDTH] <= mem_wdat[i*BYTEWIDTH +: BYTEWIDTH];
            end
        end
    end

    // For a port A read during a write, return the word after the write: new lanes plus the old remaining lanes.
    always_comb begin
        rd_a     = mem[bus.address_a];
        merged_a = rd_a;
        for (int i = 0; i < NB; i++) begin
            if (bus.byteena_a[i]) merged_a[i*BYTEWIDTH +: BYTEWIDTH] = bus.data_a[i*BYTEWIDTH +: BYTEWIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_a_s1 <= '0;
            q_b_s1 <= '0;
        end else if (busy_int) begin
            q_a_s1 <= CLEAR_VALUE;
            q_b_s1 <= CLEAR_VALUE;
        end else begin
            q_a_s1 <= bus.wren_a ? merged_a : rd_a;
            q_b_s1 <= mem[bus.address_b];
        end
    end

    generate
        if (OUTREG != 0) begin : g_outreg
            logic [DATAWIDTH-1:0] q_a_s2, q_b_s2;
            always_ff @(posedge clock) begin
                if (reset) begin
                    q_a_s2 <= '0;
                    q_b_s2 <= '0;
                end else begin
                    q_a_s2 <= q_a_s1;
                    q_b_s2 <= q_b_s1;
                end
            end
            assign bus.q_a = q_a_s2;
            assign bus.q_b = q_b_s2;
        end else begin : g_direct
            assign bus.q_a = q_a_s1;
            assign bus.q_b = q_b_s1;
        end
    endgenerate

    assign bus.busy = busy_int;
endmodule

// File: tb/tb_ram_bank.sv
// Directed checks of ram_bank: clear engine, byte lanes, read latency and same-address collisions.
// The bench drives two instances in lockstep: OUTREG=0 (dut0) and OUTREG=1 (dut1), both with CLEAR_VALUE=A5A5.
`timescale 1ns/1ps
module tb_ram_bank;
    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    ram_bank_if #(.DATAWIDTH(16), .ADDRWIDTH(4), .BYTEWIDTH(8)) if0 ();
    ram_bank_if #(.DATAWIDTH(16), .ADDRWIDTH(4), .BYTEWIDTH(8)) if1 ();

    ram_bank #(.DATAWIDTH(16), .ADDRWIDTH(4), .BYTEWIDTH(8), .OUTREG(0),
               .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5))
        dut0 (.clock(clock), .reset(reset), .bus(if0));

    ram_bank #(.DATAWIDTH(16), .ADDRWIDTH(4), .BYTEWIDTH(8), .OUTREG(1),
               .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5))
        dut1 (.clock(clock), .reset(reset), .bus(if1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic [3:0] addr, input logic [15:0] dat,
                           input logic wr, input logic [1:0] be);
        if0.address_a = addr; if0.data_a = dat; if0.wren_a = wr; if0.byteena_a = be;
        if1.address_a = addr; if1.data_a = dat; if1.wren_a = wr; if1.byteena_a = be;
    endtask

    task automatic drive_b(input logic [3:0] addr);
        if0.address_b = addr;
        if1.address_b = addr;
    endtask

    task automatic drive_clear(input logic v);
        if0.clear = v;
        if1.clear = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int k;

        reset = 1'b1;
        drive_a(4'd0, 16'h0000, 1'b0, 2'b00);
        drive_b(4'd0);
        drive_clear(1'b0);

        // 1: a clear starts on reset and runs for exactly 16 busy cycles.
        step;
        step;
        reset = 1'b0;
        check("rst_busy", 32'(if0.busy), 32'd1);
        check("rst_q_a0", 32'(if0.q_a), 32'h0);
        check("rst_q_b0", 32'(if0.q_b), 32'h0);
        check("rst_q_a1", 32'(if1.q_a), 32'h0);
        n = 0;
        while (if0.busy === 1'b1 && n < 64) begin
            step;
            n++;
        end
        check("t1_busy_cycles", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            drive_b(4'(i));
            step;
            check($sformatf("t1_rd_b%0d", i), 32'(if0.q_b), 32'hA5A5);
        end

        // 2: a full-word write, then a read with 1-cycle latency on both ports.
        drive_a(4'd3, 16'h1234, 1'b1, 2'b11);
        step;
        drive_a(4'd4, 16'h0000, 1'b0, 2'b00);
        step;
        check("t2_q_a_addr4", 32'(if0.q_a), 32'hA5A5);
        drive_a(4'd3, 16'h0000, 1'b0, 2'b00);
        drive_b(4'd3);
        step;
        check("t2_q_a", 32'(if0.q_a), 32'h1234);
        check("t2_q_b", 32'(if0.q_b), 32'h1234);

        // 3: byte-lane merges at address 5.
        drive_a(4'd5, 16'h1234, 1'b1, 2'b11);
        step;
        drive_a(4'd5, 16'hABCD, 1'b1, 2'b01);
        step;
        check("t3_rdw_lo", 32'(if0.q_a), 32'h12CD);
        drive_a(4'd5, 16'h0000, 1'b0, 2'b00);
        drive_b(4'd5);
        step;
        check("t3_rd_lo", 32'(if0.q_b), 32'h12CD);
        drive_a(4'd5, 16'hEF00, 1'b1, 2'b10);
        step;
        check("t3_rdw_hi", 32'(if0.q_a), 32'hEFCD);
        drive_a(4'd5, 16'h0000, 1'b0, 2'b00);
        step;
        check("t3_rd_hi", 32'(if0.q_b), 32'hEFCD);
        drive_a(4'd5, 16'h9999, 1'b1, 2'b00);
        step;
        check("t3_rdw_none", 32'(if0.q_a), 32'hEFCD);
        drive_a(4'd5, 16'h0000, 1'b0, 2'b00);
        step;
        check("t3_rd_none", 32'(if0.q_b), 32'hEFCD);

        // 4: port A writes and port B reads address 7 in the same cycle.
        drive_a(4'd7, 16'h0000, 1'b1, 2'b11);
        step;
        drive_a(4'd7, 16'h5555, 1'b1, 2'b11);
        drive_b(4'd7);
        step;
        check("t4_q_a_new", 32'(if0.q_a), 32'h5555);
        check("t4_q_b_old", 32'(if0.q_b), 32'h0000);
        drive_a(4'd7, 16'h0000, 1'b0, 2'b00);
        step;
        check("t4_q_b_next", 32'(if0.q_b), 32'h5555);

        // 5: back-to-back reads with the extra output register (dut1).
        drive_a(4'd1, 16'h1111, 1'b1, 2'b11);
        step;
        drive_a(4'd2, 16'h2222, 1'b1, 2'b11);
        step;
        drive_a(4'd4, 16'h0000, 1'b0, 2'b00);
        step;
        step;
        check("t5_pre", 32'(if1.q_a), 32'hA5A5);
        drive_a(4'd1, 16'h0000, 1'b0, 2'b00);
        step;
        check("t5_not_yet", 32'(if1.q_a), 32'hA5A5);
        check("t5_lat1_ref", 32'(if0.q_a), 32'h1111);
        drive_a(4'd2, 16'h0000, 1'b0, 2'b00);
        step;
        check("t5_rd1", 32'(if1.q_a), 32'h1111);
        drive_a(4'd3, 16'h0000, 1'b0, 2'b00);
        step;
        check("t5_rd2", 32'(if1.q_a), 32'h2222);
        step;
        check("t5_rd3", 32'(if1.q_a), 32'h1234);

        // 6: a clear request mid-clear is ignored, and port A writes are dropped while busy.
        drive_a(4'd3, 16'h0000, 1'b0, 2'b00);
        drive_clear(1'b1);
        step;
        drive_clear(1'b0);
        n = 0;
        k = 0;
        while (if0.busy === 1'b1 && k < 64) begin
            n++;
            if (k == 2) check("t6_q_a_busy", 32'(if0.q_a), 32'hA5A5);
            if (k == 5) begin
                drive_clear(1'b1);
                drive_a(4'd1, 16'h1357, 1'b1, 2'b11);
            end
            if (k == 6) drive_clear(1'b0);
            if (k == 7) drive_a(4'd1, 16'h0000, 1'b0, 2'b00);
            step;
            k++;
        end
        check("t6_busy_cycles", 32'(n), 32'd16);
        drive_b(4'd1);
        step;
        check("t6_write_blocked", 32'(if0.q_b), 32'hA5A5);

        // A reset mid-clear restarts the clear from address 0.
        drive_clear(1'b1);
        step;
        drive_clear(1'b0);
        step;
        step;
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        check("t6_rst_busy", 32'(if0.busy), 32'd1);
        check("t6_rst_q_b", 32'(if0.q_b), 32'h0);
        n = 0;
        while (if0.busy === 1'b1 && n < 64) begin
            step;
            n++;
        end
        check("t6_restart_cycles", 32'(n), 32'd16);
        drive_b(4'd15);
        step;
        check("t6_after_rd", 32'(if0.q_b), 32'hA5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
